note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player_pkg.sv | 16 +
 rtl/note_player_frequency_rom.sv | 38 +++
 rtl/note_player.sv | 113 +++++++++++
 tb/tb_note_player.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared types and sizing for the note player and its pitch table.
package note_player_pkg;

  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;
  localparam int PHASE_W   = 20;
  localparam int SAMPLE_W  = 16;
  localparam int AMPLITUDE = 8192;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// Combinational pitch table: note index -> 20-bit phase step.
// Entries follow an equal-tempered scale: one octave of base steps,
// doubled per octave, so entries 1..63 increase strictly and entry 0 is 0.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);

  logic [NOTE_W-1:0]  idx;
  logic [2:0]         octave;
  logic [3:0]         semi;
  logic [PHASE_W-1:0] base;

  // Split the index into octave and semitone, then scale the base step.
  always_comb begin
    idx    = note - NOTE_W'(1);
    octave = 3'(idx / NOTE_W'(12));
    semi   = 4'(idx % NOTE_W'(12));
    case (semi)
      4'd0:    base = PHASE_W'(8000);
      4'd1:    base = PHASE_W'(8476);
      4'd2:    base = PHASE_W'(8980);
      4'd3:    base = PHASE_W'(9514);
      4'd4:    base = PHASE_W'(10079);
      4'd5:    base = PHASE_W'(10679);
      4'd6:    base = PHASE_W'(11314);
      4'd7:    base = PHASE_W'(11986);
      4'd8:    base = PHASE_W'(12699);
      4'd9:    base = PHASE_W'(13454);
      4'd10:   base = PHASE_W'(14254);
      default: base = PHASE_W'(15102);
    endcase
    step = (note == '0) ? '0 : (base << octave);
  end

endmodule

// File: rtl/note_player.sv
// Square-wave note player: counts a note's duration in beats and emits
// one signed sample per sample_tick while the note is sounding.
module note_player
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic                       beat,
  input  logic                       sample_tick,
  input  logic [NOTE_W-1:0]          note,
  input  logic [DUR_W-1:0]           duration,
  input  logic                       new_note,
  output logic                       note_done,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  state_t                      state_q, state_d;
  logic [DUR_W-1:0]            beats_left_q, beats_left_d;
  logic [NOTE_W-1:0]           note_q, note_d;
  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic                        note_done_q, note_done_d;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                        sample_valid_q, sample_valid_d;
  logic [PHASE_W-1:0]          step;

  function automatic logic signed [SAMPLE_W-1:0] square_level(input logic active,
                                                              input logic msb);
    if (!active)  return '0;
    else if (msb) return -SAMPLE_W'(AMPLITUDE);
    else          return SAMPLE_W'(AMPLITUDE);
  endfunction

  frequency_rom u_rom (
    .note (note_q),
    .step (step)
  );

  // Next-state logic: new_note pre-empts everything, then play/pause and beat counting.
  always_comb begin
    state_d        = state_q;
    beats_left_d   = beats_left_q;
    note_d         = note_q;
    phase_d        = phase_q;
    note_done_d    = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = sample_tick;

    if (new_note) begin
      note_d       = note;
      beats_left_d = duration;
      phase_d      = '0;
      if (duration == '0) begin
        state_d     = S_IDLE;
        note_done_d = 1'b1;
      end else begin
        state_d = play ? S_PLAYING : S_PAUSED;
      end
    end else begin
      case (state_q)
        S_PLAYING: begin
          if (!play) begin
            state_d = S_PAUSED;
          end else begin
            if (sample_tick && (note_q != '0))
              phase_d = phase_q + step;
            if (beat && (beats_left_q != '0)) begin
              beats_left_d = beats_left_q - DUR_W'(1);
              if (beats_left_q == DUR_W'(1)) begin
                state_d     = S_IDLE;
                note_done_d = 1'b1;
              end
            end
          end
        end
        S_PAUSED: if (play) state_d = S_PLAYING;
        default:  state_d = S_IDLE;
      endcase
    end

    // The sample reflects the state and phase as they stand after this edge.
    if (sample_tick)
      sample_d = square_level((state_d == S_PLAYING) && (note_d != '0),
                              phase_d[PHASE_W-1]);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      beats_left_q   <= '0;
      note_q         <= '0;
      phase_q        <= '0;
      note_done_q    <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_left_q   <= beats_left_d;
      note_q         <= note_d;
      phase_q        <= phase_d;
      note_done_q    <= note_done_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign note_done    = note_done_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a sample scoreboard and a small
// behavioural reference of the beat/phase rules.
module tb_note_player;
  import note_player_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0, beat = 1'b0, sample_tick = 1'b0, new_note = 1'b0;
  logic [5:0] note = '0, duration = '0;
  logic note_done, sample_valid;
  logic signed [15:0] sample;

  logic [5:0]  rom_note = '0;
  logic [19:0] rom_step;

  int pass_cnt = 0;
  int total_cnt = 0;

  state_t      m_state = S_IDLE;
  logic [5:0]  m_beats = '0;
  logic [5:0]  m_note = '0;
  logic [19:0] m_phase = '0;
  logic        m_force = 1'b0;
  logic signed [15:0] sb[$];

  note_player dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .beat         (beat),
    .sample_tick  (sample_tick),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .note_done    (note_done),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  frequency_rom u_tb_rom (
    .note (rom_note),
    .step (rom_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference steps for the notes this bench plays.
  function automatic logic [19:0] ref_step(input logic [5:0] n);
    if (m_force) return 20'h40000;
    case (n)
      6'd3:    return 20'd8980;
      6'd4:    return 20'd9514;
      6'd5:    return 20'd10079;
      6'd7:    return 20'd11314;
      6'd10:   return 20'd13454;
      default: return 20'd0;
    endcase
  endfunction

  task automatic drive(input logic p, input logic b, input logic t,
                       input logic [5:0] n, input logic [5:0] d, input logic nn);
    logic exp_done;
    logic signed [15:0] exp_s;
    exp_done = 1'b0;
    play = p; beat = b; sample_tick = t; note = n; duration = d; new_note = nn;
    if (nn) begin
      m_note = n; m_beats = d; m_phase = '0;
      if (d == 0) begin
        m_state = S_IDLE; exp_done = 1'b1;
      end else begin
        m_state = p ? S_PLAYING : S_PAUSED;
      end
    end else if (m_state == S_PLAYING) begin
      if (!p) m_state = S_PAUSED;
      else begin
        if (t && m_note != 0) m_phase = m_phase + ref_step(m_note);
        if (b && m_beats != 0) begin
          m_beats = m_beats - 6'd1;
          if (m_beats == 0) begin
            m_state = S_IDLE; exp_done = 1'b1;
          end
        end
      end
    end else if (m_state == S_PAUSED && p) begin
      m_state = S_PLAYING;
    end
    if (m_state == S_PLAYING && m_note != 0) exp_s = m_phase[19] ? -16'sd8192 : 16'sd8192;
    else exp_s = 16'sd0;
    if (t) sb.push_back(exp_s);
    @(posedge clk); #1;
    chk("note_done", {31'd0, note_done}, {31'd0, exp_done});
    chk("sample_valid", {31'd0, sample_valid}, {31'd0, t});
    if (sample_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sample", {16'd0, sample}, {16'd0, sb.pop_front()});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(play, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_note_done"}, {31'd0, note_done}, 32'd0);
    chk({tag, "_sample"}, {16'd0, sample}, 32'd0);
    chk({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
    chk({tag, "_state"}, {30'd0, dut.state_q}, {30'd0, S_IDLE});
  endtask

  initial begin
    logic [19:0] prev;
    logic [19:0] held_phase;

    // Pitch table: entry 0 is zero, entries 1..63 strictly increase.
    rom_note = 6'd0; #1;
    chk("rom_entry0", {12'd0, rom_step}, 32'd0);
    prev = rom_step;
    for (int i = 1; i < 64; i++) begin
      rom_note = 6'(i); #1;
      chk("rom_monotonic", {31'd0, (rom_step > prev)}, 32'd1);
      prev = rom_step;
    end

    // Reset state.
    check_cleared("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Scenario 1: note 10, three beats.
    drive(1, 0, 1, 6'd10, 6'd3, 1);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    chk("s1_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    drive(1, 0, 1, 0, 0, 0);
    idle(2);

    // Scenario 2: pause in the middle of a four-beat note.
    drive(1, 0, 1, 6'd5, 6'd4, 1);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    held_phase = m_phase;
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
    end
    chk("s2_phase_hold", {12'd0, dut.phase_q}, {12'd0, held_phase});
    chk("s2_beats_hold", {26'd0, dut.beats_left_q}, 32'd2);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);

    // Scenario 3: a rest sounds nothing but still counts beats.
    drive(1, 0, 1, 6'd0, 6'd2, 1);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);

    // Scenario 4: forced quarter-wrap step, tick every cycle.
    force dut.step = 20'h40000;
    m_force = 1'b1;
    drive(1, 0, 1, 6'd1, 6'd63, 1);
    for (int i = 0; i < 9; i++) drive(1, 0, 1, 0, 0, 0);
    release dut.step;
    m_force = 1'b0;

    // Scenario 5: new note on the expiring beat wins, no note_done.
    drive(1, 0, 0, 6'd3, 6'd1, 1);
    drive(1, 1, 1, 6'd7, 6'd2, 1);
    chk("s5_beats", {26'd0, dut.beats_left_q}, 32'd2);
    chk("s5_note", {26'd0, dut.note_q}, 32'd7);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Scenario 6: reset mid-note, then a zero-length note is accepted.
    drive(1, 0, 1, 6'd4, 6'd5, 1);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    chk("s6_beats_before", {26'd0, dut.beats_left_q}, 32'd3);
    reset = 1'b1; #1;
    check_cleared("s6_reset");
    m_state = S_IDLE; m_beats = '0; m_note = '0; m_phase = '0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 6'd4, 6'd0, 1);
    drive(1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
